// File: rtl/color_classifier.sv
// rtl/color_classifier.sv - RGB threshold classifier with frame framing and per-class counts
// Two-stage pipeline: stage 1 registers compare results, stage 2 encodes and writes.
module color_classifier #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       iColumnas,
  input  logic [15:0]       iFilas,
  input  logic [DATA_W-1:0] th_high,
  input  logic [DATA_W-1:0] th_low,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  output logic              write,
  output logic [1:0]        write_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W:0]   red_count,
  output logic [ADDR_W:0]   green_count,
  output logic [ADDR_W:0]   blue_count,
  output logic              busy,
  output logic              oDone,
  output logic              dropped
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cols_q, cols_d, rows_q, rows_d, x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]   th_high_q, th_high_d, th_low_q, th_low_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s1_red_q, s1_red_d, s1_green_q, s1_green_d, s1_blue_q, s1_blue_d;
  logic                write_q, write_d;
  logic [1:0]          write_data_q, write_data_d;
  logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
  logic [CW-1:0]       wr_q, wr_d, wg_q, wg_d, wb_q, wb_d;
  logic [CW-1:0]       red_count_q, red_count_d, green_count_q, green_count_d;
  logic [CW-1:0]       blue_count_q, blue_count_d;
  logic                dropped_q, dropped_d;

  logic arm, hi_r, hi_g, hi_b, lo_r, lo_g, lo_b;

  always_comb begin
    state_d       = state_q;
    cols_d        = cols_q;
    rows_d        = rows_q;
    x_d           = x_q;
    y_d           = y_q;
    th_high_d     = th_high_q;
    th_low_d      = th_low_q;
    addr_d        = addr_q;
    s1_valid_d    = 1'b0;
    s1_addr_d     = s1_addr_q;
    s1_red_d      = s1_red_q;
    s1_green_d    = s1_green_q;
    s1_blue_d     = s1_blue_q;
    write_d       = 1'b0;
    write_data_d  = write_data_q;
    write_addr_d  = write_addr_q;
    wr_d          = wr_q;
    wg_d          = wg_q;
    wb_d          = wb_q;
    red_count_d   = red_count_q;
    green_count_d = green_count_q;
    blue_count_d  = blue_count_q;
    dropped_d     = dropped_q;

    hi_r = in_r >= th_high_q;
    hi_g = in_g >= th_high_q;
    hi_b = in_b >= th_high_q;
    lo_r = in_r < th_low_q;
    lo_g = in_g < th_low_q;
    lo_b = in_b < th_low_q;

    arm = start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (arm) begin
          cols_d    = iColumnas;
          rows_d    = iFilas;
          th_high_d = th_high;
          th_low_d  = th_low;
          x_d       = '0;
          y_d       = '0;
          addr_d    = '0;
          wr_d      = '0;
          wg_d      = '0;
          wb_d      = '0;
          if (iColumnas == 16'd0 || iFilas == 16'd0) begin
            state_d       = DONE;
            red_count_d   = '0;
            green_count_d = '0;
            blue_count_d  = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          s1_valid_d = 1'b1;
          s1_addr_d  = addr_q;
          s1_red_d   = hi_r & lo_g & lo_b;
          s1_green_d = lo_r & hi_g & lo_b;
          s1_blue_d  = lo_r & lo_g & hi_b;
          addr_d     = addr_q + 1'b1;
          if (x_q == cols_q - 16'd1) begin
            x_d = '0;
            y_d = y_q + 16'd1;
            if (y_q == rows_q - 16'd1) state_d = FLUSH;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      FLUSH: begin
        // Stage 2 has already folded the last pixel into the working counts.
        if (!s1_valid_q) begin
          state_d       = DONE;
          red_count_d   = wr_q;
          green_count_d = wg_q;
          blue_count_d  = wb_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arm) dropped_d = 1'b0;
    else if (in_valid && state_q != RUN) dropped_d = 1'b1;

    if (s1_valid_q) begin
      write_d      = 1'b1;
      write_addr_d = s1_addr_q;
      if (s1_red_q) begin
        write_data_d = 2'd1;
        if (wr_q != CNT_MAX) wr_d = wr_q + 1'b1;
      end else if (s1_green_q) begin
        write_data_d = 2'd2;
        if (wg_q != CNT_MAX) wg_d = wg_q + 1'b1;
      end else if (s1_blue_q) begin
        write_data_d = 2'd3;
        if (wb_q != CNT_MAX) wb_d = wb_q + 1'b1;
      end else begin
        write_data_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cols_q        <= '0;
      rows_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      th_high_q     <= '0;
      th_low_q      <= '0;
      addr_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_red_q      <= 1'b0;
      s1_green_q    <= 1'b0;
      s1_blue_q     <= 1'b0;
      write_q       <= 1'b0;
      write_data_q  <= '0;
      write_addr_q  <= '0;
      wr_q          <= '0;
      wg_q          <= '0;
      wb_q          <= '0;
      red_count_q   <= '0;
      green_count_q <= '0;
      blue_count_q  <= '0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cols_q        <= cols_d;
      rows_q        <= rows_d;
      x_q           <= x_d;
      y_q           <= y_d;
      th_high_q     <= th_high_d;
      th_low_q      <= th_low_d;
      addr_q        <= addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_red_q      <= s1_red_d;
      s1_green_q    <= s1_green_d;
      s1_blue_q     <= s1_blue_d;
      write_q       <= write_d;
      write_data_q  <= write_data_d;
      write_addr_q  <= write_addr_d;
      wr_q          <= wr_d;
      wg_q          <= wg_d;
      wb_q          <= wb_d;
      red_count_q   <= red_count_d;
      green_count_q <= green_count_d;
      blue_count_q  <= blue_count_d;
      dropped_q     <= dropped_d;
    end
  end

  assign write       = write_q;
  assign write_data  = write_data_q;
  assign write_addr  = write_addr_q;
  assign red_count   = red_count_q;
  assign green_count = green_count_q;
  assign blue_count  = blue_count_q;
  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign oDone       = (state_q == DONE);
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_color_classifier.sv
// tb/tb_color_classifier.sv - scoreboard bench for color_classifier
// Expected writes are queued as pixels are driven and popped as the DUT writes.
module tb_color_classifier;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] iColumnas = '0, iFilas = '0;
  logic [7:0]  th_high = '0, th_low = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        write;
  logic [1:0]  write_data;
  logic [12:0] write_addr;
  logic [13:0] red_count, green_count, blue_count;
  logic        busy, oDone, dropped;

  color_classifier dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .iColumnas(iColumnas), .iFilas(iFilas), .th_high(th_high), .th_low(th_low),
    .in_valid(in_valid), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .write(write), .write_data(write_data), .write_addr(write_addr),
    .red_count(red_count), .green_count(green_count), .blue_count(blue_count),
    .busy(busy), .oDone(oDone), .dropped(dropped)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [12:0] addr;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  int   next_addr = 0;
  int   exp_r = 0, exp_g = 0, exp_b = 0;
  logic [7:0] cur_thh, cur_thl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [7:0] r, g, b, thh, thl);
    logic [1:0] c;
    c = 2'd0;
    if (b >= thh && r < thl && g < thl) c = 2'd3;
    if (g >= thh && r < thl && b < thl) c = 2'd2;
    if (r >= thh && g < thl && b < thl) c = 2'd1;
    return c;
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (oDone) done_pulses++;
      if (write) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(write_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("write_addr", 32'(write_addr), 32'(e.addr));
          check("write_data", 32'(write_data), 32'(e.code));
        end
      end
    end
  end

  // Entered and left at a falling edge.
  task automatic start_frame(input int cols, input int rows, input logic [7:0] thh, input logic [7:0] thl);
    iColumnas = 16'(cols);
    iFilas    = 16'(rows);
    th_high   = thh;
    th_low    = thl;
    cur_thh   = thh;
    cur_thl   = thl;
    next_addr = 0;
    exp_r = 0; exp_g = 0; exp_b = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drive_pixel(input logic [7:0] r, g, b, input bit expect_write);
    logic [1:0] c;
    in_valid = 1'b1;
    in_r = r; in_g = g; in_b = b;
    if (expect_write) begin
      c = classify(r, g, b, cur_thh, cur_thl);
      sb.push_back({13'(next_addr), c});
      next_addr++;
      if (c == 2'd1) exp_r++;
      if (c == 2'd2) exp_g++;
      if (c == 2'd3) exp_b++;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (!oDone && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("odone_seen", 32'(oDone), 32'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_red"},   32'(red_count),   32'(exp_r));
    check({tag, "_green"}, 32'(green_count), 32'(exp_g));
    check({tag, "_blue"},  32'(blue_count),  32'(exp_b));
  endtask

  task automatic small_frame();
    start_frame(4, 2, 8'd200, 8'd50);
    check("busy_run", 32'(busy), 32'd1);
    for (int rep = 0; rep < 2; rep++) begin
      drive_pixel(8'd255, 8'd0,   8'd0,   1);
      drive_pixel(8'd0,   8'd255, 8'd0,   1);
      drive_pixel(8'd0,   8'd0,   8'd255, 1);
      drive_pixel(8'd100, 8'd100, 8'd100, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clock);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_odone", 32'(oDone), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_red", 32'(red_count), 32'd0);
    check("rst_green", 32'(green_count), 32'd0);
    check("rst_blue", 32'(blue_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 4x2 reference frame; oDone follows the last sample edge by two edges.
    done_pulses = 0;
    small_frame();
    check("busy_flush", 32'(busy), 32'd1);
    wait_done(k);
    check("done_latency", 32'(k), 32'd3);
    check_counts("frame4x2");
    check("exp_red_is_2", 32'(exp_r), 32'd2);
    @(negedge clock);
    check("odone_cleared", 32'(oDone), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_pulses), 32'd1);
    check("sb_empty_1", 32'(sb.size()), 32'd0);

    // Overlapping thresholds: all channels match, red wins.
    start_frame(1, 1, 8'd10, 8'd250);
    drive_pixel(8'd20, 8'd20, 8'd20, 1);
    wait_done(k);
    check_counts("priority");
    @(negedge clock);

    // Pixels outside RUN are dropped and flag it; start clears the flag.
    drive_pixel(8'd255, 8'd0, 8'd0, 0);
    check("dropped_idle", 32'(dropped), 32'd1);
    start_frame(1, 1, 8'd200, 8'd50);
    check("dropped_cleared", 32'(dropped), 32'd0);
    drive_pixel(8'd0, 8'd0, 8'd255, 1);
    drive_pixel(8'd0, 8'd255, 8'd0, 0);
    check("dropped_flush", 32'(dropped), 32'd1);
    wait_done(k);
    check_counts("dropframe");
    @(negedge clock);

    // Empty frame goes straight to DONE with zero counts.
    start_frame(0, 3, 8'd200, 8'd50);
    wait_done(k);
    check("zero_latency", 32'(k), 32'd1);
    check_counts("zero");
    repeat (3) @(negedge clock);
    check("sb_empty_zero", 32'(sb.size()), 32'd0);

    // Full 80x60 red frame.
    start_frame(80, 60, 8'd200, 8'd50);
    for (int i = 0; i < 4800; i++) drive_pixel(8'd210, 8'd10, 8'd10, 1);
    wait_done(k);
    check_counts("frame80x60");
    check("big_red", 32'(red_count), 32'd4800);
    @(negedge clock);
    check("sb_empty_big", 32'(sb.size()), 32'd0);

    // Reset in the middle of a frame.
    start_frame(80, 60, 8'd200, 8'd50);
    for (int i = 0; i < 37; i++) drive_pixel(8'd210, 8'd10, 8'd10, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_odone", 32'(oDone), 32'd0);
    check("mid_rst_red", 32'(red_count), 32'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    small_frame();
    wait_done(k);
    check_counts("after_rst");
    @(negedge clock);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
